d_reg_shift_burst: RTL

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with complementary outputs and an asynchronous active-low reset.
- Modes: parallel load, logical shifts, rotates and arithmetic shift.
- A burst FSM applies one shift or rotate operation a programmed number of times, then pulses done.
- Used as a general-purpose storage, serialiser and barrel-step element in the sequential design library.

---
 rtl/d_reg_shift_burst.sv | 139 +++++++++++++
 1 files changed

// File: rtl/d_reg_shift_burst.sv
// WIDTH-bit register with load, shift, rotate and arithmetic-shift modes.
// A burst FSM repeats one shift/rotate op count times, then pulses done.
//
// Ports:
//   clk, reset_n         clock, async active-low reset
//   clr                  sync clear (q to RESET_VALUE, FSM to IDLE)
//   en, mode, d          single-op enable, op select, load data
//   sin_lsb, sin_msb     serial inputs for shift left / shift right
//   start, count         burst request and length (sampled in IDLE)
//   q, q_not             register contents and its complement
//   ser_out_msb/lsb      q[WIDTH-1] and q[0]
//   busy, done           burst in progress / one-cycle completion pulse
module d_reg_shift_burst #(
    parameter int unsigned WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_not,
    output logic             ser_out_msb,
    output logic             ser_out_lsb,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       mode_q, mode_d;
    logic             start_ok;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             s_lsb,
        input logic             s_msb
    );
        logic [WIDTH-1:0] r;
        r = cur;
        case (op)
            M_LOAD:  r = ld;
            M_SHL:   r = {cur[WIDTH-2:0], s_lsb};
            M_SHR:   r = {s_msb, cur[WIDTH-1:1]};
            M_ROL:   r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROR:   r = {cur[0], cur[WIDTH-1:1]};
            M_ASR:   r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            default: r = cur;
        endcase
        return r;
    endfunction

    // Only the five shift/rotate modes with a non-zero length start a burst.
    assign start_ok = start && (count != '0) &&
                      (mode >= M_SHL) && (mode <= M_ASR);

    always_comb begin
        q_d     = q_q;
        state_d = state_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        if (clr) begin
            q_d     = RESET_VALUE;
            state_d = IDLE;
            rem_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        mode_d  = mode;
                        rem_d   = count;
                        state_d = RUN;
                    end else if (en) begin
                        q_d = apply_op(mode, q_q, d, sin_lsb, sin_msb);
                    end
                end
                RUN: begin
                    q_d   = apply_op(mode_q, q_q, d, sin_lsb, sin_msb);
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q     <= RESET_VALUE;
            state_q <= IDLE;
            rem_q   <= '0;
            mode_q  <= M_HOLD;
        end else begin
            q_q     <= q_d;
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    assign q           = q_q;
    assign q_not       = ~q_q;
    assign ser_out_msb = q_q[WIDTH-1];
    assign ser_out_lsb = q_q[0];
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);

endmodule
